echo_delay: RTL and testbench

Single-voice echo/delay effect stage between the ADC capture path (`SPI_interface`) and the DAC output path (`IPS_interface`). It accepts one 12-bit offset-binary sample per `in_valid` strobe and reads a delayed sample from an on-chip circular buffer. It mixes the attenuated delayed sample into the dry sample with saturation, writes the result back to the buffer as feedback, and presents the mixed sample to the DAC path with a one-cycle `out_valid`.

---
 rtl/echo_delay.sv | 122 ++++++++++++
 tb/tb_echo_delay.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/echo_delay.sv
// Single-voice echo stage: mixes an attenuated delayed sample from a circular
// buffer into the dry sample, saturates, and writes the mix back as feedback.
module echo_delay #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DEPTH_LOG2-1:0] delay_len,
    input  logic [2:0]            fb_shift,
    input  logic                  bypass,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] ram [DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr, fill, rd_ptr;

    logic signed [DATA_W-1:0] s_p0;
    logic [DEPTH_LOG2-1:0]    dly_p0;
    logic [2:0]               shift_p0;
    logic                     byp_p0;

    logic signed [DATA_W-1:0] d_p1;
    logic                     dvld_p1;

    logic signed [DATA_W-1:0] y_p2;
    logic signed [DATA_W-1:0] d_eff, e_mix, y_mix;
    logic signed [DATA_W:0]   sum_mix;

    // Offset binary <-> two's complement is the same MSB flip in both directions.
    function automatic logic [DATA_W-1:0] flip_msb(input logic [DATA_W-1:0] v);
        return {~v[DATA_W-1], v[DATA_W-2:0]};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return v[DATA_W-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = READ;
            READ:    state_nxt = MIX;
            MIX:     state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == WRITE);
    assign rd_ptr    = wr_ptr - dly_p0;

    always_comb begin
        d_eff   = dvld_p1 ? d_p1 : '0;
        e_mix   = d_eff >>> shift_p0;
        sum_mix = {s_p0[DATA_W-1], s_p0} + {e_mix[DATA_W-1], e_mix};
        y_mix   = byp_p0 ? s_p0 : sat(sum_mix);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            fill     <= '0;
            overrun  <= 1'b0;
            out_data <= {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            state <= state_nxt;
            if (in_valid && state != IDLE)
                overrun <= 1'b1;
            if (state == MIX)
                out_data <= flip_msb(y_mix);
            if (state == WRITE) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (fill != FILL_MAX)
                    fill <= fill + DEPTH_LOG2'(1);
            end
        end
    end

    // p0: capture sample and per-sample controls on acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            s_p0     <= flip_msb(in_data);
            dly_p0   <= delay_len;
            shift_p0 <= fb_shift;
            byp_p0   <= bypass;
        end
    end

    // p1: synchronous RAM read; stale contents are masked by the fill count
    always_ff @(posedge clk) begin
        if (state == READ) begin
            d_p1    <= ram[rd_ptr];
            dvld_p1 <= (dly_p0 != '0) && (fill >= dly_p0);
        end
    end

    // p2: mixed result held for the feedback write
    always_ff @(posedge clk) begin
        if (state == MIX)
            y_p2 <= y_mix;
        if (state == WRITE && !reset)
            ram[wr_ptr] <= y_p2;
    end

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay: impulse echo, saturation, bypass, overrun,
// mid-operation reset and buffer wrap on a 16-entry instance.
module tb_echo_delay;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [11:0] in_data;
    logic [9:0]  delay_len;
    logic [3:0]  delay_len_b;
    logic [2:0]  fb_shift;
    logic        bypass;

    logic        ova, busya, ovra;
    logic [11:0] oda;
    logic        ovb, busyb, ovrb;
    logic [11:0] odb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    echo_delay #(.DEPTH_LOG2(10), .DATA_W(12)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .delay_len(delay_len), .fb_shift(fb_shift), .bypass(bypass),
        .out_valid(ova), .out_data(oda), .busy(busya), .overrun(ovra)
    );

    echo_delay #(.DEPTH_LOG2(4), .DATA_W(12)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .delay_len(delay_len_b), .fb_shift(fb_shift), .bypass(bypass),
        .out_valid(ovb), .out_data(odb), .busy(busyb), .overrun(ovrb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One sample: expects out_valid three cycles after acceptance.
    task automatic feed(input bit sel, input logic [11:0] din, input logic [11:0] exp,
                        input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = din;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 2; n <= 8; n++) begin
            @(negedge clk);
            if ((sel ? ovb : ova) === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " data"}, sel ? odb : oda, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] imp_exp [12];
        int          cnt;
        imp_exp = '{12'hFFF, 12'h800, 12'h800, 12'h800, 12'hBFF, 12'h800,
                    12'h800, 12'h800, 12'h9FF, 12'h800, 12'h800, 12'h800};

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 12'h800;
        delay_len   = '0;
        delay_len_b = '0;
        fb_shift    = '0;
        bypass      = 1'b0;

        do_reset();
        check("rst out_valid", ova, 0);
        check("rst out_data", oda, 12'h800);
        check("rst busy", busya, 0);
        check("rst overrun", ovra, 0);
        check("rst out_data b", odb, 12'h800);

        delay_len = 10'd4;
        fb_shift  = 3'd1;
        for (int k = 0; k < 12; k++)
            feed(1'b0, (k == 0) ? 12'hFFF : 12'h800, imp_exp[k], $sformatf("impulse %0d", k));

        do_reset();
        delay_len = 10'd1;
        fb_shift  = 3'd0;
        for (int k = 0; k < 3; k++)
            feed(1'b0, 12'hFFF, 12'hFFF, $sformatf("sat pos %0d", k));
        do_reset();
        for (int k = 0; k < 3; k++)
            feed(1'b0, 12'h000, 12'h000, $sformatf("sat neg %0d", k));

        bypass = 1'b1;
        feed(1'b0, 12'h123, 12'h123, "bypass 0");
        feed(1'b0, 12'hABC, 12'hABC, "bypass 1");
        bypass    = 1'b0;
        delay_len = 10'd0;
        feed(1'b0, 12'h456, 12'h456, "zero delay 0");
        feed(1'b0, 12'h9A5, 12'h9A5, "zero delay 1");

        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'h3C5;
        @(negedge clk);
        check("ovr busy n1", busya, 1);
        check("ovr flag n1", ovra, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr flag n2", ovra, 1);
        check("ovr busy n2", busya, 1);
        check("ovr valid n2", ova, 0);
        @(negedge clk);
        check("ovr valid n3", ova, 1);
        check("ovr busy n3", busya, 1);
        check("ovr data n3", oda, 12'h3C5);
        @(negedge clk);
        check("ovr valid n4", ova, 0);
        check("ovr busy n4", busya, 0);
        in_valid = 1'b1;
        in_data  = 12'h5A5;
        @(negedge clk);
        in_valid = 1'b0;
        check("ovr accept n5", busya, 1);
        check("ovr held n5", ovra, 1);
        @(negedge clk);
        @(negedge clk);
        check("ovr valid n7", ova, 1);
        check("ovr data n7", oda, 12'h5A5);
        do_reset();
        check("ovr cleared", ovra, 0);

        delay_len = 10'd4;
        for (int k = 0; k < 6; k++)
            feed(1'b0, 12'hFFF, 12'hFFF, $sformatf("prefill %0d", k));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst valid", ova, 0);
        check("midrst busy", busya, 0);
        check("midrst data", oda, 12'h800);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ova === 1'b1) cnt++;
        end
        check("midrst no pulse", cnt, 0);
        for (int k = 0; k < 5; k++)
            feed(1'b0, 12'h800, 12'h800, $sformatf("post reset %0d", k));

        do_reset();
        delay_len   = 10'd0;
        delay_len_b = 4'd15;
        fb_shift    = 3'd0;
        for (int k = 0; k < 40; k++) begin
            int y;
            y = (k < 15) ? k : (k < 30) ? (2 * k - 15) : (3 * k - 45);
            feed(1'b1, 12'h800 + 12'(k), 12'h800 + 12'(y), $sformatf("wrap %0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
